// File: rtl/sdatop_rx.sv
// sdatop_rx -- scl/sda link receiver.
//   Oversamples scl/sda on sclk. It detects a start condition, shifts in DATA_W
//   bits MSB first, and commits the word when the stop condition arrives. The
//   word is presented as a binary value plus a registered one-hot decode.
// Ports:
//   sclk        system clock, all flops on its rising edge
//   rst         asynchronous reset, active-low
//   scl, sda    serial clock / data from the sender (asynchronous to sclk)
//   data_out    last good word, held until the next good frame
//   data_valid  one-cycle pulse when data_out/outhigh update
//   outhigh     one-hot of data_out (bit[data_out] = 1)
//   frame_err   one-cycle pulse on a malformed frame
module sdatop_rx #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   scl,
  input  logic                   sda,
  output logic [DATA_W-1:0]      data_out,
  output logic                   data_valid,
  output logic [(2**DATA_W)-1:0] outhigh,
  output logic                   frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int OH_W  = 2 ** DATA_W;
  localparam logic [OH_W-1:0] OH_ONE = OH_W'(1);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_STOP} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_p_q, scl_p_d;
  logic                   sda_p_q, sda_p_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic [OH_W-1:0]        outhigh_q, outhigh_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic scl_s, sda_s, rise, start_c, stop_c;
  logic commit, err;

  // Synchroniser and one-sample history.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_p_d    = scl_s;
    sda_p_d    = sda_s;
  end

  assign scl_s   = scl_sync_q[SYNC_STAGES-1];
  assign sda_s   = sda_sync_q[SYNC_STAGES-1];
  assign rise    = !scl_p_q & scl_s;
  assign start_c = sda_p_q & !sda_s & scl_s;
  assign stop_c  = !sda_p_q & sda_s & scl_s;

  // State register, plus all flops. The synchroniser resets to the
  // sender's idle bus levels so that release does not fake an edge.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '0;
      scl_p_q      <= 1'b1;
      sda_p_q      <= 1'b0;
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      outhigh_q    <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_p_q      <= scl_p_d;
      sda_p_q      <= sda_p_d;
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      outhigh_q    <= outhigh_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state logic. The if/else order gives start > stop > rise.
  // A stop that lands on the same sample as a scl rise is still a stop.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    commit  = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = RECV;
          count_d = '0;
        end
      end
      RECV: begin
        if (start_c) begin
          err     = 1'b1;
          count_d = '0;
        end else if (stop_c) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          shift_d = {shift_q[DATA_W-2:0], sda_s};
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(DATA_W - 1)) state_d = WAIT_STOP;
        end
      end
      WAIT_STOP: begin
        if (start_c) begin
          err     = 1'b1;
          state_d = RECV;
          count_d = '0;
        end else if (stop_c) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The word registers change only on commit.
  always_comb begin
    data_out_d   = data_out_q;
    outhigh_d    = outhigh_q;
    data_valid_d = commit;
    frame_err_d  = err;
    if (commit) begin
      data_out_d = shift_q;
      outhigh_d  = OH_ONE << shift_q;
    end
  end

  assign data_out   = data_out_q;
  assign outhigh    = outhigh_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sdatop_rx.sv
// tb_sdatop_rx -- directed bench for sdatop_rx. It drives scl/sda like the
// sender, counts data_valid/frame_err cycles and checks the held outputs.
module tb_sdatop_rx;

  logic        sclk = 1'b0;
  logic        rst  = 1'b0;
  logic        scl  = 1'b1;
  logic        sda  = 1'b0;
  logic [3:0]  data_out;
  logic        data_valid;
  logic [15:0] outhigh;
  logic        frame_err;

  int vectors = 0;
  int fails   = 0;
  int dv_cnt  = 0;
  int fe_cnt  = 0;

  sdatop_rx #(.DATA_W(4), .SYNC_STAGES(2)) dut (
    .sclk(sclk), .rst(rst), .scl(scl), .sda(sda),
    .data_out(data_out), .data_valid(data_valid),
    .outhigh(outhigh), .frame_err(frame_err)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (data_valid) dv_cnt++;
    if (frame_err)  fe_cnt++;
    assert (!(data_valid && frame_err)) else begin
      fails++;
      $error("FAIL excl: observed data_valid=1 frame_err=1 expected not both");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    repeat (4) @(negedge sclk);
  endtask

  task automatic send_start();
    if (sda == 1'b0) begin
      sda = 1'b1;
      step();
    end
    sda = 1'b0;
    step();
  endtask

  task automatic send_bit(input logic b);
    scl = 1'b0; step();
    sda = b;    step();
    scl = 1'b1; step();
  endtask

  task automatic send_bits(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_stop();
    scl = 1'b0; step();
    sda = 1'b0; step();
    scl = 1'b1;
    sda = 1'b1;
    step(); step();
  endtask

  task automatic frame(input logic [3:0] v);
    send_start();
    send_bits(v);
    send_stop();
  endtask

  int dv0, fe0, lat;

  initial begin
    // reset state
    #2;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_outhigh", 32'(outhigh), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    repeat (3) @(negedge sclk);
    rst = 1'b1;
    step();

    // 1: 4'b1011, with stop-to-data_valid latency measured
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_start();
    send_bits(4'b1011);
    scl = 1'b0; step();
    sda = 1'b0; step();
    scl = 1'b1;
    sda = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge sclk);
      if (data_valid && lat == 0) lat = k;
    end
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    chk("t1_frame_err", 32'(fe_cnt - fe0), 32'd0);
    chk("t1_data_out", 32'(data_out), 32'hB);
    chk("t1_outhigh", 32'(outhigh), 32'h0800);

    // 2: back-to-back 4'h0 then 4'hF, start one cycle after stop
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_start();
    send_bits(4'h0);
    scl = 1'b0; step();
    sda = 1'b0; step();
    scl = 1'b1;
    sda = 1'b1;
    @(negedge sclk);
    sda = 1'b0;
    step();
    chk("t2_outhigh_a", 32'(outhigh), 32'h0001);
    chk("t2_data_out_a", 32'(data_out), 32'h0);
    send_bits(4'hF);
    send_stop();
    chk("t2_dv_pulses", 32'(dv_cnt - dv0), 32'd2);
    chk("t2_frame_err", 32'(fe_cnt - fe0), 32'd0);
    chk("t2_data_out_b", 32'(data_out), 32'hF);
    chk("t2_outhigh_b", 32'(outhigh), 32'h8000);

    // 3: stop after 2 bits, then good frame 4'h6
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_stop();
    chk("t3_frame_err", 32'(fe_cnt - fe0), 32'd1);
    chk("t3_no_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("t3_data_held", 32'(data_out), 32'hF);
    chk("t3_outhigh_held", 32'(outhigh), 32'h8000);
    frame(4'h6);
    chk("t3_data_out", 32'(data_out), 32'h6);
    chk("t3_outhigh", 32'(outhigh), 32'h0040);

    // 4: repeated start after 3 bits, then full frame 4'h5
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    sda = 1'b0;
    step();
    send_bits(4'h5);
    send_stop();
    chk("t4_frame_err", 32'(fe_cnt - fe0), 32'd1);
    chk("t4_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    chk("t4_data_out", 32'(data_out), 32'h5);
    chk("t4_outhigh", 32'(outhigh), 32'h0020);

    // 5: async reset during bit 2, then frame 4'h3
    send_start();
    send_bit(1'b1);
    scl = 1'b0; step();
    sda = 1'b0;
    @(negedge sclk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_rst_data_out", 32'(data_out), 32'h0);
    chk("t5_rst_outhigh", 32'(outhigh), 32'h0);
    scl = 1'b1;
    sda = 1'b0;
    step();
    rst = 1'b1;
    step();
    dv0 = dv_cnt; fe0 = fe_cnt;
    frame(4'h3);
    chk("t5_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    chk("t5_frame_err", 32'(fe_cnt - fe0), 32'd0);
    chk("t5_data_out", 32'(data_out), 32'h3);
    chk("t5_outhigh", 32'(outhigh), 32'h0008);

    // 6: fifth scl rise before stop, then a good frame proves IDLE
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_start();
    send_bits(4'hA);
    send_bit(1'b1);
    send_stop();
    chk("t6_frame_err", 32'(fe_cnt - fe0), 32'd1);
    chk("t6_no_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("t6_data_held", 32'(data_out), 32'h3);
    chk("t6_outhigh_held", 32'(outhigh), 32'h0008);
    frame(4'h9);
    chk("t6_data_out", 32'(data_out), 32'h9);
    chk("t6_outhigh", 32'(outhigh), 32'h0200);
    chk("t6_dv_total", 32'(dv_cnt - dv0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
